// File: rtl/wb_regfile.sv
// Writeback stage of the five-stage MIPS pipeline: decodes the W instruction,
// selects/extends writeback data and owns the 32x32 GPR file with two read ports.
module wb_regfile #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_W,
    input  logic [31:0] PC_W,
    input  logic [31:0] PC8_W,
    input  logic [31:0] AO_W,
    input  logic [31:0] MDO_W,
    input  logic [31:0] DR_W,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        WE_W,
    output logic [4:0]  WA_W,
    output logic [31:0] WD_W
);
    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_JAL  = 6'h03, OP_ADDIU = 6'h09,
                           OP_SLTI    = 6'h0a, OP_SLTIU = 6'h0b, OP_ANDI = 6'h0c,
                           OP_ORI     = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f,
                           OP_LB      = 6'h20, OP_LH   = 6'h21, OP_LW    = 6'h23,
                           OP_LBU     = 6'h24, OP_LHU  = 6'h25;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_SLLV = 6'h04,
                           F_SRLV = 6'h06, F_SRAV = 6'h07, F_JALR = 6'h09, F_MFHI = 6'h10,
                           F_MFLO = 6'h12, F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND  = 6'h24,
                           F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2a,
                           F_SLTU = 6'h2b;

    logic [31:0] r_regs [32];
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_wr;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic        w_unused;

    assign w_op     = IR_W[31:26];
    assign w_funct  = IR_W[5:0];
    assign w_rt     = IR_W[20:16];
    assign w_rd     = IR_W[15:11];
    assign w_unused = ^{PC_W, IR_W[25:21], IR_W[10:6]};

    // Byte/halfword lane selection uses the low address bits of the load EA.
    function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [31:0] word,
                                             input logic [1:0] ofs);
        logic [7:0]  b;
        logic [15:0] h;
        case (ofs)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = ofs[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0, h};
            default: load_ext = word;
        endcase
    endfunction

    always_comb begin
        w_wr = 1'b0;
        w_wa = w_rd;
        w_wd = AO_W;
        case (w_op)
            OP_SPECIAL: begin
                case (w_funct)
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADDU, F_SUBU,
                    F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        w_wr = 1'b1;
                    end
                    F_JALR: begin
                        w_wr = 1'b1;
                        w_wd = PC8_W;
                    end
                    F_MFHI, F_MFLO: begin
                        w_wr = 1'b1;
                        w_wd = MDO_W;
                    end
                    default: w_wr = 1'b0;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
                w_wr = 1'b1;
                w_wa = w_rt;
            end
            OP_JAL: begin
                w_wr = 1'b1;
                w_wa = 5'd31;
                w_wd = PC8_W;
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                w_wr = 1'b1;
                w_wa = w_rt;
                w_wd = load_ext(w_op, DR_W, AO_W[1:0]);
            end
            default: w_wr = 1'b0;
        endcase
    end

    // Gating on a nonzero destination keeps $0 hardwired and makes nop a non-write.
    assign WE_W = w_wr && (w_wa != 5'd0);
    assign WA_W = w_wa;
    assign WD_W = w_wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i[4:0]] <= (i == 0) ? 32'h0 : RESET_VAL;
            end
        end else if (WE_W) begin
            r_regs[WA_W] <= WD_W;
        end
    end

    assign RD1 = (A1 == 5'd0) ? 32'h0 :
                 (BYPASS_EN && WE_W && (A1 == WA_W)) ? WD_W : r_regs[A1];
    assign RD2 = (A2 == 5'd0) ? 32'h0 :
                 (BYPASS_EN && WE_W && (A2 == WA_W)) ? WD_W : r_regs[A2];
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a bypassing instance (RESET_VAL=0) and a
// non-bypassing instance (nonzero RESET_VAL) driven in parallel.
module tb_wb_regfile;
    localparam logic [31:0] RV_B = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_W, PC_W, PC8_W, AO_W, MDO_W, DR_W;
    logic [4:0]  A1, A2;
    logic [31:0] rd1_a, rd2_a, wd_a, rd1_b, rd2_b, wd_b;
    logic        we_a, we_b;
    logic [4:0]  wa_a, wa_b;

    always #5 clk = ~clk;

    wb_regfile #(.RESET_VAL(32'h0), .BYPASS_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC_W(PC_W), .PC8_W(PC8_W), .AO_W(AO_W),
        .MDO_W(MDO_W), .DR_W(DR_W), .A1(A1), .A2(A2), .RD1(rd1_a), .RD2(rd2_a),
        .WE_W(we_a), .WA_W(wa_a), .WD_W(wd_a));

    wb_regfile #(.RESET_VAL(RV_B), .BYPASS_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .IR_W(IR_W), .PC_W(PC_W), .PC8_W(PC8_W), .AO_W(AO_W),
        .MDO_W(MDO_W), .DR_W(DR_W), .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
        .WE_W(we_b), .WA_W(wa_b), .WD_W(wd_b));

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_a [32];
    logic [31:0] m_b [32];

    int OPS [23] = '{0, 0, 0, 0, 9, 12, 13, 14, 15, 10, 11, 3, 32, 33, 35, 36, 37, 43, 40, 4, 5, 2, 16};
    int FNS [22] = '{'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h00, 'h02, 'h03,
                     'h04, 'h06, 'h07, 'h09, 'h10, 'h12, 'h08, 'h11, 'h13, 'h18, 'h1b};

    // Load result computed arithmetically: shift the lane down, mask, then sign-correct.
    function automatic logic [31:0] ref_load(input int op, input logic [31:0] dr, input logic [1:0] ofs);
        longint v;
        if (op == 'h23) return dr;
        if (op == 'h20 || op == 'h24) begin
            v = longint'((dr >> (8 * ofs)) & 32'hFF);
            if (op == 'h20 && v >= 128) v = v - 256;
        end else begin
            v = longint'((dr >> (16 * ofs[1])) & 32'hFFFF);
            if (op == 'h21 && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic void ref_wb(input logic [31:0] ir, ao, pc8, mdo, dr,
                                   output bit we, output logic [4:0] wa, output logic [31:0] wd);
        int op = int'(ir[31:26]);
        int fn = int'(ir[5:0]);
        bit wr = 0;
        wa = 5'd0;
        wd = 32'h0;
        if (op == 0) begin
            if (fn inside {'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b, 'h00, 'h02, 'h03, 'h04, 'h06, 'h07}) begin
                wr = 1; wa = ir[15:11]; wd = ao;
            end else if (fn == 'h09) begin
                wr = 1; wa = ir[15:11]; wd = pc8;
            end else if (fn inside {'h10, 'h12}) begin
                wr = 1; wa = ir[15:11]; wd = mdo;
            end
        end else if (op inside {'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e, 'h0f}) begin
            wr = 1; wa = ir[20:16]; wd = ao;
        end else if (op == 'h03) begin
            wr = 1; wa = 5'd31; wd = pc8;
        end else if (op inside {'h20, 'h21, 'h23, 'h24, 'h25}) begin
            wr = 1; wa = ir[20:16]; wd = ref_load(op, dr, ao[1:0]);
        end
        we = wr && (wa != 5'd0);
    endfunction

    function automatic logic [31:0] rd_exp(input bit inst_b, input logic [4:0] a, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (!inst_b && we && a == wa) return wd;
        return inst_b ? m_b[a] : m_a[a];
    endfunction

    task automatic push(input int kind, input logic [31:0] exp, input string name);
        chk_t c;
        c.cyc = cyc; c.kind = kind; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    task automatic step(input bit rst, input logic [31:0] ir, ao, pc8, mdo, dr,
                        input logic [4:0] a1, a2, input bit chk);
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        reset = rst; IR_W = ir; AO_W = ao; PC8_W = pc8; MDO_W = mdo; DR_W = dr;
        A1 = a1; A2 = a2; PC_W = $urandom;
        ref_wb(ir, ao, pc8, mdo, dr, we, wa, wd);
        if (chk) begin
            push(0, {31'h0, we}, "we");
            if (we) begin
                push(1, {27'h0, wa}, "wa");
                push(2, wd, "wd");
            end
            push(3, rd_exp(0, a1, we, wa, wd), "rd1_byp");
            push(4, rd_exp(0, a2, we, wa, wd), "rd2_byp");
            push(5, rd_exp(1, a1, we, wa, wd), "rd1_nobyp");
            push(6, rd_exp(1, a2, we, wa, wd), "rd2_nobyp");
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_a[i] = 32'h0;
                m_b[i] = (i == 0) ? 32'h0 : RV_B;
            end
        end else if (we) begin
            m_a[wa] = wd;
            m_b[wa] = wd;
        end
        cyc++;
        #1;
    endtask

    // Monitor: at each falling edge, drain the expectations for the current cycle.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                c = q.pop_front();
                case (c.kind)
                    0:       act = {31'h0, we_a};
                    1:       act = {27'h0, wa_a};
                    2:       act = wd_a;
                    3:       act = rd1_a;
                    4:       act = rd2_a;
                    5:       act = rd1_b;
                    default: act = rd2_b;
                endcase
                n_checks++;
                if (act !== c.exp || c.cyc != cyc) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d: got %h expected %h", c.name, c.cyc, act, c.exp);
                end
            end
        end
    end

    initial begin
        logic [31:0] r, ir;
        logic [4:0]  a1, a2;
        int          op, fn;
        reset = 1'b1; IR_W = 0; PC_W = 0; PC8_W = 0; AO_W = 0; MDO_W = 0; DR_W = 0; A1 = 0; A2 = 0;
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0, 5'd5, 5'd31, 0);
        step(1, 0, 0, 0, 0, 0, 5'd5, 5'd31, 1);
        step(0, 0, 0, 0, 0, 0, 5'd5, 5'd31, 1);
        // ori $8,$0,0x1234 with same-cycle read, then registered read
        step(0, 32'h3408_1234, 32'h1234, 0, 0, 0, 5'd8, 5'd0, 1);
        step(0, 0, 0, 0, 0, 0, 5'd8, 5'd8, 1);
        // byte/halfword loads into $9
        step(0, 32'h8009_0000, 32'h0000_1001, 0, 0, 32'h80FF_7F01, 5'd9, 5'd8, 1);
        step(0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 1);
        step(0, 32'h8009_0000, 32'h0000_1002, 0, 0, 32'h80FF_7F01, 5'd9, 5'd8, 1);
        step(0, 32'h9009_0000, 32'h0000_1003, 0, 0, 32'h80FF_7F01, 5'd9, 5'd8, 1);
        step(0, 32'h8409_0000, 32'h0000_1002, 0, 0, 32'h80FF_7F01, 5'd9, 5'd8, 1);
        step(0, 32'h9409_0000, 32'h0000_1001, 0, 0, 32'h80FF_7F01, 5'd9, 5'd8, 1);
        step(0, 32'h8C09_0000, 32'h0000_1000, 0, 0, 32'h80FF_7F01, 5'd9, 5'd8, 1);
        step(0, 0, 0, 0, 0, 0, 5'd9, 5'd8, 1);
        // jal, then jalr with rd=0
        step(0, 32'h0C00_0100, 32'h5, 32'h0000_3010, 0, 0, 5'd31, 5'd0, 1);
        step(0, 0, 0, 0, 0, 0, 5'd31, 5'd9, 1);
        step(0, 32'h03E0_0009, 32'h5, 32'h0000_4444, 0, 0, 5'd0, 5'd31, 1);
        // non-writing encodings with nonzero AO_W
        step(0, 32'hAC0A_0000, 32'hFFFF_0010, 32'h11, 32'h22, 32'h33, 5'd10, 5'd11, 1);
        step(0, 32'h100A_0004, 32'hFFFF_0010, 32'h11, 32'h22, 32'h33, 5'd10, 5'd11, 1);
        step(0, 32'h014B_0018, 32'hFFFF_0010, 32'h11, 32'h22, 32'h33, 5'd10, 5'd11, 1);
        step(0, 32'h0140_0011, 32'hFFFF_0010, 32'h11, 32'h22, 32'h33, 5'd10, 5'd11, 1);
        step(0, 0, 0, 0, 0, 0, 5'd10, 5'd11, 1);
        // mfhi $12, then reset colliding with a write to $10
        step(0, 32'h0000_6010, 32'h7, 0, 32'hCAFE_F00D, 0, 5'd12, 5'd0, 1);
        step(0, 32'h340A_5555, 32'h5555, 0, 0, 0, 5'd10, 5'd12, 1);
        step(0, 0, 0, 0, 0, 0, 5'd10, 5'd12, 1);
        step(1, 32'h340A_7777, 32'h7777, 0, 0, 0, 5'd10, 5'd12, 1);
        step(0, 0, 0, 0, 0, 0, 5'd10, 5'd12, 1);
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            op = OPS[$urandom_range(0, 22)];
            fn = FNS[$urandom_range(0, 21)];
            r  = $urandom;
            ir = {op[5:0], r[25:6], fn[5:0]};
            a1 = ($urandom_range(0, 1) == 1) ? ir[15:11] : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 1) == 1) ? ir[20:16] : 5'($urandom_range(0, 31));
            step($urandom_range(0, 49) == 0, ir, $urandom, $urandom, $urandom, $urandom, a1, a2, 1);
        end
        step(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0);
        @(negedge clk); #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage plus general-purpose register file of the five-stage MIPS pipeline.
- Sits at the consumer end of the MEM/WB pipeline register.
- Decodes the W-stage instruction, selects and extends the writeback data, and commits it to a 32x32 register array.
- Provides two combinational read ports to the decode stage, with same-cycle write-to-read bypass.

Parameters:
- RESET_VAL, 32'h00000000, value loaded into registers 1..31 on reset.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns the write data; 0 = returns the old array value.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- IR_W  input  32  instruction in W stage
- PC_W  input  32  PC of the W-stage instruction; observability only
- PC8_W  input  32  link value, PC+8
- AO_W  input  32  ALU result, or load effective address for loads
- MDO_W  input  32  HI/LO read value
- DR_W  input  32  raw aligned data-memory word
- A1  input  5  read port 1 address (rs)
- A2  input  5  read port 2 address (rt)
- RD1  output  32  read port 1 data
- RD2  output  32  read port 2 data
- WE_W  output  1  write enable of the current W instruction (combinational)
- WA_W  output  5  destination register (combinational)
- WD_W  output  32  writeback data (combinational)

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset: registers 1..31 take RESET_VAL at the posedge where reset=1. Register 0 is always 0. RD1/RD2 reflect the array one cycle after reset. WE_W/WA_W/WD_W are purely combinational and have no reset state.
- Decode (op=IR[31:26], funct=IR[5:0], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11]):
  - op=0 with funct in {addu, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav}: WA=rd, WD=AO_W.
  - op=0, funct=jalr: WA=rd, WD=PC8_W.
  - op=0, funct in {mfhi, mflo}: WA=rd, WD=MDO_W.
  - op in {addiu, andi, ori, xori, lui, slti, sltiu}: WA=rt, WD=AO_W.
  - op=jal: WA=31, WD=PC8_W.
  - op in {lw, lh, lhu, lb, lbu}: WA=rt, WD=load-extended DR_W.
  - All other encodings (stores, branches, j, jr, mult/div, mthi/mtlo, eret, unknown): WE_W=0.
- WE_W = decoded write AND WA_W != 0. IR_W=0 (nop) therefore yields WE_W=0.
- Load extension:
  - lw: WD = DR_W.
  - lh/lhu: halfword DR_W[31:16] if AO_W[1]=1, else DR_W[15:0]; sign/zero extend respectively; AO_W[0] is ignored.
  - lb/lbu: byte selected by AO_W[1:0] (00 = [7:0], 11 = [31:24]); sign/zero extend.
- Commit: at posedge clk with reset=0 and WE_W=1, reg[WA_W] <= WD_W. One write per cycle.
- Read: RD1 = (A1==0) ? 0 : (BYPASS_EN && WE_W && A1==WA_W) ? WD_W : reg[A1]. RD2 is identical using A2.
- Reset asserted while a write is pending: reset wins and the write is dropped.
- Writes to $0 are never stored, whatever the decode result.

Test Plan:
- Reset with RESET_VAL=0 -> RD1/RD2 read 0 for A1=5, A2=31; IR_W=0 gives WE_W=0.
- IR_W=ori $8,$0,0x1234 (0x34081234), AO_W=0x1234 -> WE_W=1, WA_W=8, and in the same cycle RD1=0x1234 with A1=8 (bypass). Next cycle reg8=0x1234 with IR_W=0. With BYPASS_EN=0 the same-cycle RD1 reads the old value 0.
- lb to $9 with DR_W=0x80FF7F01, AO_W low bits 01 -> WD=0x0000007F. Low bits 10 -> WD=0xFFFFFFFF. lbu with low bits 11 -> WD=0x00000080. lh with AO_W[1]=1 -> WD=0xFFFF80FF.
- jal with PC8_W=0x00003010 -> reg31=0x00003010. jalr rd=0 -> WE_W=0 and reg0 stays 0.
- sw, beq, mult, and mthi encodings with nonzero AO_W -> WE_W=0 and no register changes.
- Write to $10 issued in the same cycle reset=1 -> reg10=RESET_VAL afterwards.
